// File: rtl/gate_meas.sv
// ----------------------------------------------------------------------------
// gate_meas -- equal-precision frequency measurement channel
//
// Purpose
//   Measures the frequency of an asynchronous input by running back-to-back
//   gates that open and close on rising edges of the measured signal.
//   During a gate the channel counts reference clocks (ref_cnt) and signal
//   rising edges (sig_cnt):  f_sig = sig_cnt / ref_cnt * f_clk.
//   Because a gate always spans a whole number of signal periods, the relative
//   error depends only on the reference clock, not on the measured frequency.
//   Gates are contiguous: the edge that closes one gate opens the next.
//   If no edge shows up within TIMEOUT cycles while waiting (ARM or CLOSE),
//   a timeout record is published instead of a measurement.
//   Results go out through a single valid/ready holding register. A new result
//   that lands on an unconsumed one overwrites it and raises res_ovf_o.
//
// Parameters
//   CNT_W      width of the ref/sig counters and the result fields
//   GATE_TIME  minimum gate length in clk_i cycles (>= 2)
//   TIMEOUT    max cycles spent waiting for a signal edge in ARM/CLOSE (>= 2)
//
// Ports
//   clk_i        in   1      system clock
//   rst_n_i      in   1      asynchronous active-low reset
//   gate_en_i    in   1      channel enable (level); 0 aborts any gate
//   sig_i        in   1      measured signal, asynchronous to clk_i
//   res_ref_o    out  CNT_W  result: reference cycles in gate
//   res_sig_o    out  CNT_W  result: signal rising edges in gate
//   res_to_o     out  1      result is a timeout record (counts are 0)
//   res_ovf_o    out  1      this result overwrote an unconsumed one
//   res_valid_o  out  1      result register holds unconsumed data
//   res_ready_i  in   1      consumer takes the result when valid & ready
// ----------------------------------------------------------------------------
module gate_meas #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned GATE_TIME = 100_000_000,
    parameter int unsigned TIMEOUT   = 200_000_000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             gate_en_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] res_ref_o,
    output logic [CNT_W-1:0] res_sig_o,
    output logic             res_to_o,
    output logic             res_ovf_o,
    output logic             res_valid_o,
    input  logic             res_ready_i
);

    // Wait counter only ever holds 0 .. TIMEOUT-1.
    localparam int unsigned          WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     GATE_LEN  = CNT_W'(GATE_TIME);

    typedef enum logic [1:0] {
        ST_IDLE,   // channel disabled
        ST_ARM,    // waiting for the first edge to open a gate
        ST_MEAS,   // gate open, minimum length not reached yet
        ST_CLOSE   // minimum length reached, waiting for the closing edge
    } state_e;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic              sig_s1_q, sig_s1_d;
    logic              sig_s2_q, sig_s2_d;
    logic              sig_s3_q, sig_s3_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic [CNT_W-1:0]  sig_cnt_q, sig_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  res_ref_q, res_ref_d;
    logic [CNT_W-1:0]  res_sig_q, res_sig_d;
    logic              res_to_q, res_to_d;
    logic              res_ovf_q, res_ovf_d;
    logic              res_valid_q, res_valid_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             sig_edge;    // one-cycle pulse per rising edge of sig_i
    logic [CNT_W-1:0] ref_inc;
    logic [CNT_W-1:0] sig_inc;
    logic             gate_done;   // this cycle completes the minimum gate length
    logic             wait_done;   // edge wait expires this cycle
    logic             pub;         // publish event
    logic             pub_to;
    logic [CNT_W-1:0] pub_ref;
    logic [CNT_W-1:0] pub_sig;

    // The sync + delay latency is the same for opening and closing edges, so
    // it shifts the gate in time without changing its length.
    assign sig_edge  = sig_s2_q & ~sig_s3_q;
    assign ref_inc   = sat_inc(ref_cnt_q);
    assign sig_inc   = sat_inc(sig_cnt_q);
    assign gate_done = (ref_inc >= GATE_LEN);
    assign wait_done = (wait_cnt_q == WAIT_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic: input sync, gate FSM and counters
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        sig_s1_d   = sig_i;
        sig_s2_d   = sig_s1_q;
        sig_s3_d   = sig_s2_q;
        state_d    = state_q;
        ref_cnt_d  = ref_cnt_q;
        sig_cnt_d  = sig_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pub        = 1'b0;
        pub_to     = 1'b0;
        pub_ref    = '0;
        pub_sig    = '0;

        if (!gate_en_i) begin
            // Disable wins over everything; partial counts are thrown away
            // and nothing is published.
            state_d    = ST_IDLE;
            ref_cnt_d  = '0;
            sig_cnt_d  = '0;
            wait_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ARM;
                    ref_cnt_d  = '0;
                    sig_cnt_d  = '0;
                    wait_cnt_d = '0;
                end

                ST_ARM: begin
                    if (sig_edge) begin
                        // Opening edge: the edge itself is not counted.
                        state_d    = ST_MEAS;
                        ref_cnt_d  = '0;
                        sig_cnt_d  = '0;
                        wait_cnt_d = '0;
                    end else if (wait_done) begin
                        pub        = 1'b1;
                        pub_to     = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end

                ST_MEAS: begin
                    ref_cnt_d = ref_inc;
                    if (sig_edge) begin
                        if (gate_done) begin
                            // Closing edge counts in this gate and opens the next.
                            pub       = 1'b1;
                            pub_ref   = ref_inc;
                            pub_sig   = sig_inc;
                            ref_cnt_d = '0;
                            sig_cnt_d = '0;
                        end else begin
                            sig_cnt_d = sig_inc;
                        end
                    end else if (gate_done) begin
                        state_d    = ST_CLOSE;
                        wait_cnt_d = '0;
                    end
                end

                ST_CLOSE: begin
                    ref_cnt_d = ref_inc;
                    if (sig_edge) begin
                        pub        = 1'b1;
                        pub_ref    = ref_inc;
                        pub_sig    = sig_inc;
                        state_d    = ST_MEAS;
                        ref_cnt_d  = '0;
                        sig_cnt_d  = '0;
                        wait_cnt_d = '0;
                    end else if (wait_done) begin
                        // Signal stopped mid-gate: report it and rearm.
                        pub        = 1'b1;
                        pub_to     = 1'b1;
                        state_d    = ST_ARM;
                        ref_cnt_d  = '0;
                        sig_cnt_d  = '0;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Result holding register (valid/ready)
    // ------------------------------------------------------------------------
    always_comb begin
        res_ref_d   = res_ref_q;
        res_sig_d   = res_sig_q;
        res_to_d    = res_to_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = res_valid_q;

        if (pub) begin
            // A coincident valid&ready consumes the old result, so the new one
            // is only an overwrite when the old one is still pending.
            res_ref_d   = pub_ref;
            res_sig_d   = pub_sig;
            res_to_d    = pub_to;
            res_ovf_d   = res_valid_q & ~res_ready_i;
            res_valid_d = 1'b1;
        end else if (res_valid_q && res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sig_s1_q    <= 1'b0;
            sig_s2_q    <= 1'b0;
            sig_s3_q    <= 1'b0;
            state_q     <= ST_IDLE;
            ref_cnt_q   <= '0;
            sig_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            res_ref_q   <= '0;
            res_sig_q   <= '0;
            res_to_q    <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of the others, regardless of statement order.
            sig_s1_q    <= sig_s1_d;
            sig_s2_q    <= sig_s2_d;
            sig_s3_q    <= sig_s3_d;
            state_q     <= state_d;
            ref_cnt_q   <= ref_cnt_d;
            sig_cnt_q   <= sig_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            res_ref_q   <= res_ref_d;
            res_sig_q   <= res_sig_d;
            res_to_q    <= res_to_d;
            res_ovf_q   <= res_ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_ref_o   = res_ref_q;
    assign res_sig_o   = res_sig_q;
    assign res_to_o    = res_to_q;
    assign res_ovf_o   = res_ovf_q;
    assign res_valid_o = res_valid_q;

endmodule

// File: tb/tb_gate_meas.sv
// ----------------------------------------------------------------------------
// tb_gate_meas -- self-checking bench for gate_meas
//
// Table of signal periods with the results each must produce, applied through
// a scoreboard queue and a monitor that compares every consumed result
// (values and spacing). Hand-written sequences cover overwrite / coincident
// handshake, signal loss mid-gate, disable mid-gate and async reset.
// ----------------------------------------------------------------------------
module tb_gate_meas;

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned GATE_TIME = 100;
    localparam int unsigned TIMEOUT   = 1000;

    logic             clk_i       = 1'b0;
    logic             rst_n_i     = 1'b0;
    logic             gate_en_i   = 1'b0;
    logic             sig_i       = 1'b0;
    logic             res_ready_i = 1'b1;
    logic [CNT_W-1:0] res_ref_o;
    logic [CNT_W-1:0] res_sig_o;
    logic             res_to_o;
    logic             res_ovf_o;
    logic             res_valid_o;

    gate_meas #(
        .CNT_W     (CNT_W),
        .GATE_TIME (GATE_TIME),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .gate_en_i   (gate_en_i),
        .sig_i       (sig_i),
        .res_ref_o   (res_ref_o),
        .res_sig_o   (res_sig_o),
        .res_to_o    (res_to_o),
        .res_ovf_o   (res_ovf_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;

    always @(posedge clk_i) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Signal generator: one rising edge every sig_period clocks (0 = held low)
    // ------------------------------------------------------------------------
    int sig_period = 0;
    int phase      = 0;

    always @(negedge clk_i) begin
        if (sig_period == 0) begin
            phase = 0;
            sig_i = 1'b0;
        end else begin
            phase = (phase + 1 >= sig_period) ? 0 : phase + 1;
            sig_i = (phase >= 1) && (phase <= sig_period / 2);
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard and monitor
    // ------------------------------------------------------------------------
    typedef struct {
        longint ref_v;
        longint sig_v;
        bit     to;
        longint gap;     // expected cycles since the previous result
    } exp_t;

    exp_t   exp_q[$];
    bit     mon_en   = 1'b0;
    longint last_pop = -1;

    always @(negedge clk_i) begin
        if (mon_en && rst_n_i && res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_ref", 64'(res_ref_o), 64'(e.ref_v));
                check("sb_sig", 64'(res_sig_o), 64'(e.sig_v));
                check("sb_to",  64'(res_to_o),  64'(e.to));
                check("sb_ovf", 64'(res_ovf_o), 64'd0);
                if (last_pop >= 0)
                    check("sb_gap", 64'(cyc - last_pop), 64'(e.gap));
                last_pop = cyc;
            end
        end
    end

    // Wait (bounded) for res_valid_o seen high at a negedge.
    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (res_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic quiesce();
        gate_en_i  = 1'b0;
        sig_period = 0;
        repeat (5) @(negedge clk_i);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus table
    // ------------------------------------------------------------------------
    typedef struct {
        int     period;
        int     n_res;
        longint exp_ref;
        longint exp_sig;
        bit     exp_to;
        longint exp_gap;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit     ok;
        int     seen;
        longint t0;

        // period 10: closing edge exactly at GATE_TIME
        vecs[0] = '{period: 10, n_res: 3, exp_ref: 100, exp_sig: 10, exp_to: 0, exp_gap: 100};
        // period 7: gate stretches to the first edge at or past 100 cycles
        vecs[1] = '{period: 7,  n_res: 3, exp_ref: 105, exp_sig: 15, exp_to: 0, exp_gap: 105};
        vecs[2] = '{period: 25, n_res: 2, exp_ref: 100, exp_sig: 4,  exp_to: 0, exp_gap: 100};
        // period 33: gate goes through CLOSE
        vecs[3] = '{period: 33, n_res: 2, exp_ref: 132, exp_sig: 4,  exp_to: 0, exp_gap: 132};
        // no signal: timeout records every TIMEOUT cycles from ARM
        vecs[4] = '{period: 0,  n_res: 2, exp_ref: 0,   exp_sig: 0,  exp_to: 1, exp_gap: 1000};

        // ---- reset state ---------------------------------------------------
        #1;
        check("rst_valid", 64'(res_valid_o), 64'd0);
        check("rst_ref",   64'(res_ref_o),   64'd0);
        check("rst_sig",   64'(res_sig_o),   64'd0);
        check("rst_to",    64'(res_to_o),    64'd0);
        check("rst_ovf",   64'(res_ovf_o),   64'd0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);

        // ---- table-driven runs through the scoreboard ----------------------
        res_ready_i = 1'b1;
        foreach (vecs[i]) begin
            quiesce();
            last_pop = -1;
            for (int n = 0; n < vecs[i].n_res; n++)
                exp_q.push_back('{vecs[i].exp_ref, vecs[i].exp_sig, vecs[i].exp_to, vecs[i].exp_gap});
            sig_period = vecs[i].period;
            gate_en_i  = 1'b1;
            mon_en     = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < vecs[i].n_res * int'(vecs[i].exp_gap) + 400; c++) begin
                @(negedge clk_i);
                if (exp_q.size() == 0) begin
                    ok = 1'b1;
                    break;
                end
            end
            check($sformatf("vec%0d_drain", i), 64'(ok), 64'd1);
            exp_q.delete();
            gate_en_i = 1'b0;
            mon_en    = 1'b0;
        end

        // ---- overwrite, then ready coincident with publish -----------------
        quiesce();
        res_ready_i = 1'b0;
        sig_period  = 10;
        gate_en_i   = 1'b1;
        wait_valid(400, ok);
        check("ovf_first_valid", 64'(ok), 64'd1);
        check("ovf_first_ref",   64'(res_ref_o), 64'd100);
        check("ovf_first_ovf",   64'(res_ovf_o), 64'd0);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (res_ovf_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("ovf_seen",  64'(ok), 64'd1);
        check("ovf_valid", 64'(res_valid_o), 64'd1);
        check("ovf_ref",   64'(res_ref_o),   64'd100);
        check("ovf_sig",   64'(res_sig_o),   64'd10);
        res_ready_i = 1'b1;
        @(negedge clk_i);
        check("ovf_drop_valid", 64'(res_valid_o), 64'd0);
        check("ovf_hold_ref",   64'(res_ref_o),   64'd100);
        res_ready_i = 1'b0;
        wait_valid(200, ok);
        check("coin_first_valid", 64'(ok), 64'd1);
        check("coin_first_ovf",   64'(res_ovf_o), 64'd0);
        repeat (99) @(negedge clk_i);
        check("coin_hold_valid", 64'(res_valid_o), 64'd1);
        res_ready_i = 1'b1;            // ready lands on the next publish cycle
        @(negedge clk_i);
        check("coin_valid", 64'(res_valid_o), 64'd1);
        check("coin_ovf",   64'(res_ovf_o),   64'd0);
        @(negedge clk_i);
        check("coin_drain_valid", 64'(res_valid_o), 64'd0);

        // ---- signal stops mid-gate: one timeout from CLOSE, then ARM -------
        quiesce();
        res_ready_i = 1'b1;
        sig_period  = 10;
        gate_en_i   = 1'b1;
        wait_valid(400, ok);
        check("stop_first_valid", 64'(ok), 64'd1);
        t0 = cyc;
        sig_period = 0;
        wait_valid(2000, ok);
        check("stop_to_valid", 64'(ok), 64'd1);
        check("stop_to_flag",  64'(res_to_o),  64'd1);
        check("stop_to_ref",   64'(res_ref_o), 64'd0);
        check("stop_to_sig",   64'(res_sig_o), 64'd0);
        check("stop_to_delay", 64'(cyc - t0),  64'(GATE_TIME + TIMEOUT));
        t0 = cyc;
        wait_valid(1200, ok);
        check("arm_to_valid", 64'(ok), 64'd1);
        check("arm_to_flag",  64'(res_to_o), 64'd1);
        check("arm_to_gap",   64'(cyc - t0), 64'(TIMEOUT));

        // ---- disable mid-gate: no publish, clean restart -------------------
        quiesce();
        sig_period = 10;
        gate_en_i  = 1'b1;
        wait_valid(400, ok);
        check("dis_first_valid", 64'(ok), 64'd1);
        repeat (50) @(negedge clk_i);
        gate_en_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk_i);
            if (res_valid_o) seen++;
        end
        check("dis_no_publish", 64'(seen), 64'd0);
        gate_en_i = 1'b1;
        wait_valid(400, ok);
        check("reen_valid", 64'(ok), 64'd1);
        check("reen_ref",   64'(res_ref_o), 64'd100);
        check("reen_sig",   64'(res_sig_o), 64'd10);
        check("reen_to",    64'(res_to_o),  64'd0);

        // ---- async reset mid-gate ------------------------------------------
        res_ready_i = 1'b0;
        wait_valid(400, ok);
        check("ar_pre_valid", 64'(ok), 64'd1);
        repeat (30) @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("ar_valid", 64'(res_valid_o), 64'd0);
        check("ar_ref",   64'(res_ref_o),   64'd0);
        check("ar_sig",   64'(res_sig_o),   64'd0);
        check("ar_to",    64'(res_to_o),    64'd0);
        check("ar_ovf",   64'(res_ovf_o),   64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("ar_post_valid", 64'(res_valid_o), 64'd0);
        res_ready_i = 1'b1;
        wait_valid(400, ok);
        check("ar_run_valid", 64'(ok), 64'd1);
        check("ar_run_ref",   64'(res_ref_o), 64'd100);
        check("ar_run_sig",   64'(res_sig_o), 64'd10);
        check("ar_run_ovf",   64'(res_ovf_o), 64'd0);

        gate_en_i = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
